// File: rtl/icache_mem.sv
// icache_mem: direct-mapped 32-line instruction cache storage, `WAYS read ports.
// Optional same-cycle write-to-read forwarding under ICACHE_MEM_BYPASS_EN.
`ifndef WAYS
`define WAYS 2
`endif

module icache_mem #(
  parameter int NUM_LINES = 32,
  parameter int TAG_BITS  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [4:0]                   wr_index,
  input  logic [TAG_BITS-1:0]          wr_tag,
  input  logic [63:0]                  wr_data,
  input  logic                         flush,
  input  logic [`WAYS-1:0][31:0]       rd_addr,
  input  logic [`WAYS-1:0]             rd_en,
  output logic [`WAYS-1:0][63:0]       cachemem_data,
  output logic [`WAYS-1:0]             cachemem_valid,
  output logic [5:0]                   valid_count
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tags [NUM_LINES];
  logic [63:0]          data [NUM_LINES];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid       <= '0;
      valid_count <= '0;
      for (int l = 0; l < NUM_LINES; l++) begin
        tags[l] <= '0;
        data[l] <= '0;
      end
    end else if (flush) begin
      valid       <= '0;
      valid_count <= '0;
    end else if (wr_en) begin
      data[wr_index]  <= wr_data;
      tags[wr_index]  <= wr_tag;
      valid[wr_index] <= 1'b1;
      if (!valid[wr_index])
        valid_count <= valid_count + 6'd1;
    end
  end

  for (genvar i = 0; i < `WAYS; i++) begin : g_port
    logic [4:0]          idx;
    logic [TAG_BITS-1:0] tag;
    logic                hit;
    logic                fwd;
    logic                unused_addr;

    assign idx = rd_addr[i][7:3];
    assign tag = rd_addr[i][8 +: TAG_BITS];
    assign hit = rd_en[i] & valid[idx] & (tags[idx] == tag);
    assign unused_addr = ^{rd_addr[i][31:16], rd_addr[i][2:0]};

`ifdef ICACHE_MEM_BYPASS_EN
    assign fwd = wr_en & ~flush & rd_en[i]
               & (idx == wr_index) & (tag == wr_tag);
`else
    assign fwd = 1'b0;
`endif

    // Outputs are forced quiet while reset is held, even before the array clears.
    assign cachemem_valid[i] = ~reset & (fwd | hit);
    assign cachemem_data[i]  = reset ? 64'd0 : (fwd ? wr_data : data[idx]);
  end

endmodule

// File: tb/tb_icache_mem.sv
// tb_icache_mem: randomized + directed scoreboard bench for icache_mem.
// Expected responses come from a line-record model of the cache.
`ifndef WAYS
`define WAYS 2
`endif

module tb_icache_mem;
  localparam int W = `WAYS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wr_en;
  logic [4:0]           wr_index;
  logic [7:0]           wr_tag;
  logic [63:0]          wr_data;
  logic                 flush;
  logic [W-1:0][31:0]   rd_addr;
  logic [W-1:0]         rd_en;
  logic [W-1:0][63:0]   cachemem_data;
  logic [W-1:0]         cachemem_valid;
  logic [5:0]           valid_count;

  icache_mem dut (
    .clock          (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_index       (wr_index),
    .wr_tag         (wr_tag),
    .wr_data        (wr_data),
    .flush          (flush),
    .rd_addr        (rd_addr),
    .rd_en          (rd_en),
    .cachemem_data  (cachemem_data),
    .cachemem_valid (cachemem_valid),
    .valid_count    (valid_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]        v;
    logic [W-1:0][63:0]  d;
    int                  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: one record per line; cnt = -1 while unknown.
  bit          mv [32];
  logic [7:0]  mt [32];
  logic [63:0] md [32];
  bit          known = 0;

  function automatic int model_count();
    int n = 0;
    for (int l = 0; l < 32; l++) n += int'(mv[l]);
    return n;
  endfunction

  task automatic cycle(input bit rst, input bit we, input logic [4:0] wi,
                       input logic [7:0] wt, input logic [63:0] wd,
                       input bit fl, input logic [W-1:0][31:0] a,
                       input logic [W-1:0] en);
    exp_t e;
    bit bypass;
`ifdef ICACHE_MEM_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    @(negedge clk);
    reset = rst; wr_en = we; wr_index = wi; wr_tag = wt;
    wr_data = wd; flush = fl; rd_addr = a; rd_en = en;
    for (int p = 0; p < W; p++) begin
      int  li  = int'(a[p][7:3]);
      logic [7:0] t = a[p][15:8];
      bit fwd = bypass && we && !fl && en[p] && li == int'(wi) && t == wt;
      if (rst) begin
        e.v[p] = 1'b0;
        e.d[p] = 64'd0;
      end else begin
        e.v[p] = fwd || (en[p] && mv[li] && mt[li] == t);
        e.d[p] = fwd ? wd : md[li];
      end
    end
    e.cnt = known ? model_count() : -1;
    q.push_back(e);
    if (rst) begin
      for (int l = 0; l < 32; l++) begin
        mv[l] = 0; mt[l] = '0; md[l] = '0;
      end
      known = 1;
    end else if (fl) begin
      for (int l = 0; l < 32; l++) mv[l] = 0;
    end else if (we) begin
      mv[wi] = 1; mt[wi] = wt; md[wi] = wd;
    end
  endtask

  function automatic logic [31:0] mk(input int idx, input logic [7:0] t);
    mk = {16'h0000, t, idx[4:0], 3'b000};
  endfunction

  // Monitor: pops one expected response per cycle, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int p = 0; p < W; p++) begin
          checks++;
          if (cachemem_valid[p] === e.v[p]) passed++;
          else $display("FAIL valid[%0d] got %b exp %b at %0t",
                        p, cachemem_valid[p], e.v[p], $time);
          checks++;
          if (cachemem_data[p] === e.d[p]) passed++;
          else $display("FAIL data[%0d] got %h exp %h at %0t",
                        p, cachemem_data[p], e.d[p], $time);
        end
        if (e.cnt >= 0) begin
          checks++;
          if (valid_count === 6'(e.cnt)) passed++;
          else $display("FAIL valid_count got %0d exp %0d at %0t",
                        valid_count, e.cnt, $time);
        end
      end
    end
  end

  initial begin
    logic [W-1:0][31:0] a;
    logic [W-1:0] all_en;
    logic [W-1:0] en;
    int waited;
    all_en = '1;
    a = '0;
    reset = 1; wr_en = 0; wr_index = 0; wr_tag = 0;
    wr_data = 0; flush = 0; rd_addr = '0; rd_en = '0;

    cycle(1, 1, 5'd2, 8'h11, 64'h1, 0, a, all_en);
    cycle(1, 0, 0, 0, 0, 0, a, all_en);

    // Every index after reset misses with zero data.
    for (int i = 0; i < 32; i++) begin
      for (int p = 0; p < W; p++) a[p] = mk(i, 8'($urandom));
      cycle(0, 0, 0, 0, 0, 0, a, all_en);
    end

    // Fill idx 5 tag 0x12, then hit 0x1228 / miss 0x1328.
    for (int p = 0; p < W; p++) a[p] = 32'h0000_0100;
    cycle(0, 1, 5'd5, 8'h12, 64'hDEADBEEF_CAFEF00D, 0, a, all_en);
    for (int p = 0; p < W; p++) a[p] = (p % 2 == 0) ? 32'h1228 : 32'h1328;
    cycle(0, 0, 0, 0, 0, 0, a, all_en);

    // Overwrite idx 5 with tag 0x13.
    cycle(0, 1, 5'd5, 8'h13, 64'h0123_4567_89AB_CDEF, 0, a, all_en);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);

    // Fill 3 and 7, then flush colliding with a fill of idx 9.
    cycle(0, 1, 5'd3, 8'h21, 64'h3333, 0, a, all_en);
    cycle(0, 1, 5'd7, 8'h22, 64'h7777, 0, a, all_en);
    cycle(0, 1, 5'd9, 8'h23, 64'h9999, 1, a, all_en);
    for (int p = 0; p < W; p++) a[p] = mk(3, 8'h21);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);
    for (int p = 0; p < W; p++) a[p] = (p % 2 == 0) ? mk(7, 8'h22) : mk(9, 8'h23);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);

    // Same-cycle write and read of one address.
    for (int p = 0; p < W; p++) a[p] = mk(10, 8'h44);
    cycle(0, 1, 5'd10, 8'h44, 64'hA5A5_5A5A_0F0F_F0F0, 0, a, all_en);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);

    // Fill every line with a distinct tag.
    for (int i = 0; i < 32; i++) begin
      for (int p = 0; p < W; p++) a[p] = mk(i, 8'(8'h80 + i));
      cycle(0, 1, 5'(i), 8'(8'h80 + i), {32'(i), $urandom}, 0, a, all_en);
    end
    for (int p = 0; p < W; p++)
      a[p] = (p % 2 == 0) ? mk(4, 8'h84) : mk(20, 8'h94);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);
    en = all_en;
    en[W-1] = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, a, en);
    for (int p = 0; p < W; p++) a[p] = mk(4, 8'h84);
    cycle(0, 0, 0, 0, 0, 0, a, all_en);

    // Randomized traffic with a small tag space to force hits.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < W; p++)
        a[p] = {16'($urandom), 8'($urandom_range(0, 3)),
                5'($urandom), 3'($urandom)};
      en = W'($urandom);
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            5'($urandom), 8'($urandom_range(0, 3)),
            {$urandom, $urandom}, $urandom_range(0, 15) == 0, a, en);
    end

    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(negedge clk);
      #3;
      waited++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_mem.md
# icache_mem

Direct-mapped instruction cache storage array that sits directly downstream of the icache controller. It holds 32 lines of 64-bit instruction data with 8-bit tags and per-line valid bits. Lines are filled through a single write port driven by the controller's `data_write_enable`, `current_index` and `current_tag` together with `Imem2proc_data`. The block serves `WAYS` independent combinational lookups, which return `cachemem_data` / `cachemem_valid` to the controller and fetch.

## Interface
Parameters:
- `NUM_LINES`, default 32: number of lines; fixed by the 5-bit index.
- `TAG_BITS`, default 8: tag width, covering address bits [15:8].
- `` `WAYS ``, global macro: number of read ports.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  fill strobe, driven by the controller's `data_write_enable`.
- `wr_index`  in  5  fill line index.
- `wr_tag`  in  8  fill tag.
- `wr_data`  in  64  fill data, driven by `Imem2proc_data`.
- `flush`  in  1  invalidate all lines.
- `rd_addr`  in  `WAYS`×32  per-port fetch byte address.
- `rd_en`  in  `WAYS`  per-port lookup enable.
- `cachemem_data`  out  `WAYS`×64  line data for each port.
- `cachemem_valid`  out  `WAYS`  per-port hit indication.
- `valid_count`  out  6  number of valid lines, range 0–32.

## Operation
- Address split per port:
  - index = `rd_addr[i][7:3]`
  - tag = `rd_addr[i][15:8]`
  - bits [2:0] and [31:16] are ignored.
- Per-line state is `valid` (1b), `tag` (8b) and `data` (64b).
- Lookup is purely combinational from the registered array:
  - `cachemem_data[i]` = `data[idx]`
  - `cachemem_valid[i]` = `rd_en[i] & valid[idx] & (tag[idx] == rd tag)`
- `cachemem_data` is driven even on a miss. Consumers qualify it with `cachemem_valid`.
- Fill: when `wr_en` is high and `flush` is low, on the clock edge:
  - `data[wr_index]` ← `wr_data`
  - `tag[wr_index]` ← `wr_tag`
  - `valid[wr_index]` ← 1
  - An existing line at that index is overwritten unconditionally. No replacement choice exists.
- Flush: `valid` of every line ← 0 on the clock edge. Tags and data are untouched.
- `flush` and `wr_en` in the same cycle: flush wins and the write is dropped.
- `valid_count` is a registered counter:
  - +1 when a fill targets a line whose `valid` is 0.
  - Unchanged when a fill overwrites a valid line.
  - ← 0 on flush.
  - Saturation is impossible by construction (max 32). It must never exceed 32.
- Several read ports may hit the same line in one cycle. All of them return identical data, with no conflict.
- A read port may address the line being written in the same cycle. The result is governed by the bypass configuration (see Configuration).

## Timing
- Read latency is 0 cycles: outputs are combinational from state and `rd_*`.
- Write latency is 1 cycle: a fill becomes visible to lookups on the cycle after `wr_en` is sampled, unless bypass is enabled.
- Flush is visible the cycle after it is sampled.
- Reset, synchronous:
  - all `valid` ← 0, all `tag` ← 0, all `data` ← 0, `valid_count` ← 0.
  - During and after the reset cycle, every `cachemem_valid` = 0 and `cachemem_data` = 0.
- Reset asserted mid-fill: reset wins and the line is not written.
- There is no handshake. `wr_en` is a single-cycle strobe, and each asserted cycle performs one write.

## Configuration
- `ICACHE_MEM_BYPASS_EN` defined:
  - Same-cycle write-to-read forwarding is enabled.
  - Condition: `wr_en & ~flush & rd_en[i] & (rd index == wr_index) & (rd tag == wr_tag)`.
  - When the condition holds, `cachemem_data[i]` = `wr_data` and `cachemem_valid[i]` = 1 in the same cycle.
- `ICACHE_MEM_BYPASS_EN` undefined:
  - There is no forwarding. Lookups reflect only registered state.
  - A port reading the line being filled sees the old contents in that cycle and the new contents on the next cycle.

## Test plan
- Reset, then read every index with `rd_en` all 1 → all `cachemem_valid` = 0, `cachemem_data` = 0, `valid_count` = 0.
- Fill idx 5, tag 0x12, data 0xDEADBEEF_CAFEF00D; next cycle read addr 0x0000_1228 → valid = 1, data matches, `valid_count` = 1. Read addr 0x0000_1328 → valid = 0.
- Fill idx 5 again with tag 0x13 → `valid_count` stays 1. Addr 0x1328 hits and addr 0x1228 misses.
- Fill idx 3 and idx 7, then assert `flush` together with `wr_en` to idx 9 → the next cycle has all misses, `valid_count` = 0, and idx 9 is not written.
- Fill at cycle N while port 0 reads the same address at cycle N → with `ICACHE_MEM_BYPASS_EN`, hit with `wr_data` at N; without it, miss at N and hit at N+1.
- Fill all 32 indices with distinct tags, with `WAYS` ports reading the same line plus a different line → `valid_count` = 32, all enabled ports hit, and ports with `rd_en` = 0 report valid = 0.
